light_seq_dp: RTL and testbench
===============================

// Module: light_seq_dp
// PURPOSE
//  Parametrised light sequencer built as an ASM: a control unit (3-state Moore FSM) plus a
//  separate datapath (dwell timer, event counter X, snapshot register Y). Each light phase
//  lasts a configurable number of cycles. X counts visits to phase C, in wrap or saturate
//  mode. Y exposes the last snapshot of X. Sits between a request input and the light drivers.
// PARAMETERS
//  CNT_W    3  width of counter X / register Y / cnt_o (>=1)
//  TMR_W    4  dwell timer width; every DWELL_* must lie in 1..2**TMR_W
//  DWELL_A  1  cycles spent in state A (1 = single-cycle phase)
//  DWELL_B  1  cycles spent in state B
//  DWELL_C  1  cycles spent in state C
//  SATURATE 0  0: X wraps 2**CNT_W-1 -> 0; 1: X holds at 2**CNT_W-1
// PORTS
//  clk_i    in   1      clock, rising edge
//  reset_i  in   1      asynchronous, active-high reset
//  in_i     in   1      request; sampled only in the last cycle of state B
//  clr_i    in   1      synchronous clear of X and Y
//  out_o    out  3      light pattern, Moore output decoded from the state
//  cnt_o    out  CNT_W  current value of register Y
//  ovf_o    out  1      registered 1-cycle pulse: increment requested while X = max
// BEHAVIOUR
//  - Reset: state A, timer = DWELL_A-1, X = 0, Y = 0, ovf_o = 0, so out_o = 3'b100.
//  - Timer: on each state entry it loads DWELL_<next>-1, then decrements once per cycle.
//    last = (timer == 0). The state changes only on a cycle where last = 1.
//  - State A: out 100. On last -> B.
//  - State B: out 011. On last: ldy (Y <= X), then -> C if in_i = 1, else -> A.
//  - State C: out 010. In the first cycle of C: incx. On last: ldy, then -> A.
//    With DWELL_C = 1, incx and ldy fall in the same cycle; Y takes the pre-increment X.
//  - Encoding 2'b11 is illegal: out 000, next state A, no datapath control asserted.
//  - Datapath priority, per register:
//    - X: clr_i > incx > hold.
//    - Y: clr_i > ldy > hold. ldy always loads the current x_p, never x_n.
//  - Arithmetic: X + 1 is computed modulo 2**CNT_W.
//    - SATURATE = 0: max -> 0.
//    - SATURATE = 1: X stays at max.
//    - In both modes ovf_o = 1 for exactly the cycle after an incx taken at max.
//    - If clr_i is high in that cycle, ovf_o is suppressed.
//  - Reset asserted mid-dwell or mid-phase: immediate return to the reset values above.
//    There is no partial-phase memory.
//  - in_i has no effect outside the last cycle of B; its glitches there are not filtered.
//  - Latency: a state entry shows on out_o in the same cycle. cnt_o updates the cycle after ldy.
// STRUCTURE
//  - Package light_seq_pkg holds:
//    - state_t enum {STATE_A, STATE_B, STATE_C}, logic [1:0];
//    - light patterns LIGHT_A = 3'b100, LIGHT_B = 3'b011, LIGHT_C = 3'b010, LIGHT_OFF = 3'b000.
//  - Sub-module light_seq_timer (TMR_W): inputs load, load_val; output last.
//    The controller drives load on every state transition.
//  - Top level keeps the FSM (state_ff plus comb next-state and control) separate from the
//    datapath (x/y registers plus comb next-value logic). Control signals: clrx, incx, ldy, load.
// TESTING
//  1. Defaults, in_i = 0 -> out_o 100,011,100,011,...; cnt_o = 0 throughout; ovf_o never set.
//  2. Defaults, in_i = 1 -> out_o 100,011,010 repeating.
//     X = 1 after the first C; cnt_o = 1 from the cycle after the 2nd B.
//  3. DWELL_A = 3, DWELL_B = 2, DWELL_C = 2, in_i = 1 only in the 1st B cycle:
//     out_o 100 x3, then 011 x2, then back to 100. No C is entered, because in_i was low
//     in B's last cycle.
//  4. CNT_W = 2, in_i = 1, ~20 cycles:
//     - SATURATE = 0: X reads 1,2,3,0; ovf_o pulses once, after the 4th C.
//     - SATURATE = 1: X holds 3; ovf_o pulses after the 4th and every later C.
//  5. X = 2, clr_i pulsed in the 1st C cycle -> X = 0 and Y = 0 next cycle, no increment,
//     ovf_o = 0.
//  6. reset_i asserted for 1 cycle mid-dwell in B (DWELL_B = 4) -> out_o = 100 immediately,
//     cnt_o = 0, and A lasts a full DWELL_A cycles after release.

Source files
------------

// File: rtl/light_seq_pkg.sv
// Shared types and light patterns for the light sequencer.
package light_seq_pkg;

    typedef enum logic [1:0] {
        STATE_A = 2'b00,
        STATE_B = 2'b01,
        STATE_C = 2'b10
    } state_t;

    localparam logic [2:0] LIGHT_A   = 3'b100;
    localparam logic [2:0] LIGHT_B   = 3'b011;
    localparam logic [2:0] LIGHT_C   = 3'b010;
    localparam logic [2:0] LIGHT_OFF = 3'b000;

    // Moore decode; the unused encoding drives all lights off.
    function automatic logic [2:0] light_of(input logic [1:0] st);
        case (st)
            STATE_A: light_of = LIGHT_A;
            STATE_B: light_of = LIGHT_B;
            STATE_C: light_of = LIGHT_C;
            default: light_of = LIGHT_OFF;
        endcase
    endfunction

endpackage

// File: rtl/light_seq_dp_if.sv
// Request/clear inputs and light/counter outputs of the light sequencer.
interface light_seq_dp_if #(
    parameter int unsigned CNT_W = 3
);
    logic             in_i;
    logic             clr_i;
    logic [2:0]       out_o;
    logic [CNT_W-1:0] cnt_o;
    logic             ovf_o;

    modport master (output in_i, output clr_i, input out_o, input cnt_o, input ovf_o);
    modport slave  (input in_i, input clr_i, output out_o, output cnt_o, output ovf_o);
endinterface

// File: rtl/light_seq_timer.sv
// Dwell down-counter: reloaded on every state change, flags the last cycle of a phase.
module light_seq_timer #(
    parameter int unsigned     TMR_W   = 4,
    parameter logic [TMR_W-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    output logic             last_o
);
    logic [TMR_W-1:0] tmr_q, tmr_d;

    always_comb begin
        tmr_d = tmr_q;
        if (load_i) begin
            tmr_d = load_val_i;
        end else if (tmr_q != '0) begin
            tmr_d = tmr_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tmr_q <= RST_VAL;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    assign last_o = (tmr_q == '0);
endmodule

// File: rtl/light_seq_dp.sv
// Light sequencer: 3-state Moore control unit driving a dwell timer, visit counter X
// and snapshot register Y.
module light_seq_dp
    import light_seq_pkg::*;
#(
    parameter int unsigned CNT_W    = 3,
    parameter int unsigned TMR_W    = 4,
    parameter int unsigned DWELL_A  = 1,
    parameter int unsigned DWELL_B  = 1,
    parameter int unsigned DWELL_C  = 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic         clk_i,
    input  logic         reset_i,
    light_seq_dp_if.slave bus
);
    localparam logic [TMR_W-1:0] TMR_A   = TMR_W'(DWELL_A - 1);
    localparam logic [TMR_W-1:0] TMR_B   = TMR_W'(DWELL_B - 1);
    localparam logic [TMR_W-1:0] TMR_C   = TMR_W'(DWELL_C - 1);
    localparam logic [CNT_W-1:0] X_MAX   = '1;

    logic [1:0]       state_q, state_d;
    logic             first_q;
    logic             load, last, clrx, incx, ldy;
    logic [TMR_W-1:0] load_val;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             ovf_q, ovf_d;

    light_seq_timer #(
        .TMR_W  (TMR_W),
        .RST_VAL(TMR_A)
    ) u_timer (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .load_i    (load),
        .load_val_i(load_val),
        .last_o    (last)
    );

    // first_q marks the entry cycle of the current state (reset counts as an entry).
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= STATE_A;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            first_q <= load;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        incx    = 1'b0;
        ldy     = 1'b0;
        clrx    = bus.clr_i;
        case (state_q)
            STATE_A: begin
                if (last) begin
                    load    = 1'b1;
                    state_d = STATE_B;
                end
            end
            STATE_B: begin
                if (last) begin
                    ldy     = 1'b1;
                    load    = 1'b1;
                    state_d = bus.in_i ? STATE_C : STATE_A;
                end
            end
            STATE_C: begin
                incx = first_q;
                if (last) begin
                    ldy     = 1'b1;
                    load    = 1'b1;
                    state_d = STATE_A;
                end
            end
            default: begin
                load    = 1'b1;
                state_d = STATE_A;
            end
        endcase
    end

    // Timer reload value follows the state being entered.
    always_comb begin
        case (state_d)
            STATE_B: load_val = TMR_B;
            STATE_C: load_val = TMR_C;
            default: load_val = TMR_A;
        endcase
    end

    // Datapath: clear beats increment/load; Y always samples the present X.
    always_comb begin
        x_d   = x_q;
        ovf_d = 1'b0;
        if (clrx) begin
            x_d = '0;
        end else if (incx) begin
            if (x_q == X_MAX) begin
                ovf_d = 1'b1;
                x_d   = SATURATE ? x_q : '0;
            end else begin
                x_d = x_q + CNT_W'(1);
            end
        end
        y_d = clrx ? '0 : (ldy ? x_q : y_q);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            x_q   <= '0;
            y_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.out_o = light_of(state_q);
    assign bus.cnt_o = y_q;
    assign bus.ovf_o = ovf_q;
endmodule

// File: tb/tb_light_seq_dp.sv
// Directed bench for light_seq_dp: several parameterisations, hand-computed expectations.
module tb_light_seq_dp;
    import light_seq_pkg::*;

    logic clk = 1'b0;
    logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1, rst4 = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    light_seq_dp_if #(.CNT_W(3)) if0 ();
    light_seq_dp_if #(.CNT_W(3)) if1 ();
    light_seq_dp_if #(.CNT_W(2)) if2 ();
    light_seq_dp_if #(.CNT_W(2)) if3 ();
    light_seq_dp_if #(.CNT_W(3)) if4 ();

    light_seq_dp u0 (.clk_i(clk), .reset_i(rst0), .bus(if0.slave));
    light_seq_dp #(.DWELL_A(3), .DWELL_B(2), .DWELL_C(2)) u1 (.clk_i(clk), .reset_i(rst1), .bus(if1.slave));
    light_seq_dp #(.CNT_W(2), .SATURATE(1'b0)) u2 (.clk_i(clk), .reset_i(rst2), .bus(if2.slave));
    light_seq_dp #(.CNT_W(2), .SATURATE(1'b1)) u3 (.clk_i(clk), .reset_i(rst2), .bus(if3.slave));
    light_seq_dp #(.DWELL_A(3), .DWELL_B(4)) u4 (.clk_i(clk), .reset_i(rst4), .bus(if4.slave));

    // Expected sequences, index = cycle after reset release
    logic [2:0] t2_cnt [0:14] = '{0,0,0,0,0,1,1,1,2,0,0,0,0,0,1};
    logic [2:0] t3_out [0:9]  = '{3'b100,3'b100,3'b100,3'b011,3'b011,3'b100,3'b100,3'b100,3'b011,3'b011};
    logic [1:0] t4_cnt0 [0:18] = '{0,0,0,0,0,1,1,1,2,2,2,3,3,3,0,0,0,1,1};
    logic [1:0] t4_cnt1 [0:18] = '{0,0,0,0,0,1,1,1,2,2,2,3,3,3,3,3,3,3,3};
    logic [2:0] t6_out [0:4]  = '{3'b100,3'b100,3'b100,3'b011,3'b011};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] exp_out;
        if0.in_i = 1'b0; if0.clr_i = 1'b0;
        if1.in_i = 1'b0; if1.clr_i = 1'b0;
        if2.in_i = 1'b0; if2.clr_i = 1'b0;
        if3.in_i = 1'b0; if3.clr_i = 1'b0;
        if4.in_i = 1'b0; if4.clr_i = 1'b0;
        step();
        step();

        check("rst_out", 32'(if0.out_o), 32'(LIGHT_A));
        check("rst_cnt", 32'(if0.cnt_o), 32'd0);
        check("rst_ovf", 32'(if0.ovf_o), 32'd0);

        // in_i low: A/B alternate, nothing counted
        rst0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t1_out[%0d]", k), 32'(if0.out_o), (k % 2 == 0) ? 32'(LIGHT_A) : 32'(LIGHT_B));
            check($sformatf("t1_cnt[%0d]", k), 32'(if0.cnt_o), 32'd0);
            check($sformatf("t1_ovf[%0d]", k), 32'(if0.ovf_o), 32'd0);
            step();
        end

        // in_i high: A,B,C cycle; clr_i in the third C's first cycle (X = 2 there)
        rst0 = 1'b1;
        step();
        if0.in_i = 1'b1;
        rst0 = 1'b0;
        for (int k = 0; k < 15; k++) begin
            case (k % 3)
                0:       exp_out = LIGHT_A;
                1:       exp_out = LIGHT_B;
                default: exp_out = LIGHT_C;
            endcase
            check($sformatf("t2_out[%0d]", k), 32'(if0.out_o), 32'(exp_out));
            check($sformatf("t2_cnt[%0d]", k), 32'(if0.cnt_o), 32'(t2_cnt[k]));
            check($sformatf("t2_ovf[%0d]", k), 32'(if0.ovf_o), 32'd0);
            if0.clr_i = (k == 8);
            step();
        end
        if0.clr_i = 1'b0;

        // Longer dwells; request only in the first of two B cycles
        rst1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if1.in_i = (k == 3);
            check($sformatf("t3_out[%0d]", k), 32'(if1.out_o), 32'(t3_out[k]));
            check($sformatf("t3_cnt[%0d]", k), 32'(if1.cnt_o), 32'd0);
            step();
        end

        // 2-bit counter, wrap vs saturate
        if2.in_i = 1'b1;
        if3.in_i = 1'b1;
        rst2 = 1'b0;
        for (int k = 0; k < 19; k++) begin
            check($sformatf("t4w_cnt[%0d]", k), 32'(if2.cnt_o), 32'(t4_cnt0[k]));
            check($sformatf("t4w_ovf[%0d]", k), 32'(if2.ovf_o), (k == 12) ? 32'd1 : 32'd0);
            check($sformatf("t4s_cnt[%0d]", k), 32'(if3.cnt_o), 32'(t4_cnt1[k]));
            check($sformatf("t4s_ovf[%0d]", k), 32'(if3.ovf_o),
                  (k == 12 || k == 15 || k == 18) ? 32'd1 : 32'd0);
            step();
        end

        // Reset pulse in the middle of a 4-cycle B phase
        rst4 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t6a_out[%0d]", k), 32'(if4.out_o), 32'(t6_out[k]));
            step();
        end
        rst4 = 1'b1;
        #1;
        check("t6_rst_out", 32'(if4.out_o), 32'(LIGHT_A));
        check("t6_rst_cnt", 32'(if4.cnt_o), 32'd0);
        check("t6_rst_ovf", 32'(if4.ovf_o), 32'd0);
        step();
        rst4 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t6b_out[%0d]", k), 32'(if4.out_o), 32'(t6_out[k]));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
